// File: rtl/seq_detect_ctrl_if.sv
// seq_detect_ctrl_if: configuration, control, bit-stream and status signals of the sequence detector.
interface seq_detect_ctrl_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CNT_W   = 8
);
    logic               i_cfg_we;
    logic [MAX_LEN-1:0] i_cfg_pattern;
    logic [LEN_W-1:0]   i_cfg_len;
    logic               i_cfg_overlap;
    logic               i_arm;
    logic               i_disarm;
    logic               i_bit_valid;
    logic               i_bit;
    logic               o_cfg_ready;
    logic               o_busy;
    logic               o_match;
    logic               o_led;
    logic [CNT_W-1:0]   o_match_count;
    logic               o_cfg_err;

    modport master (
        output i_cfg_we, i_cfg_pattern, i_cfg_len, i_cfg_overlap,
        output i_arm, i_disarm, i_bit_valid, i_bit,
        input  o_cfg_ready, o_busy, o_match, o_led, o_match_count, o_cfg_err
    );

    modport slave (
        input  i_cfg_we, i_cfg_pattern, i_cfg_len, i_cfg_overlap,
        input  i_arm, i_disarm, i_bit_valid, i_bit,
        output o_cfg_ready, o_busy, o_match, o_led, o_match_count, o_cfg_err
    );
endinterface

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: programmable serial pattern detector with arm/disarm control,
// saturating match counter and pulse-stretched LED output.
module seq_detect_ctrl #(
    parameter int MAX_LEN  = 8,
    parameter int LEN_W    = $clog2(MAX_LEN + 1),
    parameter int CNT_W    = 8,
    parameter int HOLD_CYC = 4
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    seq_detect_ctrl_if.slave  bus
);
    localparam int TW = $clog2(HOLD_CYC + 1);

    typedef enum logic {IDLE, ARMED} state_t;

    state_t             state, state_n;
    logic [MAX_LEN-1:0] pattern, hist, hist_n, mask;
    logic [LEN_W-1:0]   len, fill, fill_inc;
    logic               overlap;
    logic [CNT_W-1:0]   count;
    logic [TW-1:0]      timer;
    logic               match_q, err_q;
    logic               arm_go, accept, cfg_ok, hit;

    always_ff @(posedge i_clock or negedge i_reset_n)
        if (!i_reset_n) state <= IDLE;
        else            state <= state_n;

    always_comb begin
        arm_go   = state == IDLE && bus.i_arm && !bus.i_disarm;
        state_n  = arm_go ? ARMED : (state == ARMED && bus.i_disarm) ? IDLE : state;
        accept   = state == ARMED && bus.i_bit_valid && !bus.i_disarm;
        cfg_ok   = state == IDLE && bus.i_cfg_we && bus.i_cfg_len != '0
                   && bus.i_cfg_len <= LEN_W'(MAX_LEN);
        hist_n   = {hist[MAX_LEN-2:0], bus.i_bit};
        fill_inc = (fill == len) ? len : fill + 1'b1;
        // bits above len are masked out; len == MAX_LEN shifts every one out
        mask     = ~({MAX_LEN{1'b1}} << len);
        hit      = accept && fill_inc == len && ((hist_n ^ pattern) & mask) == '0;
    end

    always_ff @(posedge i_clock or negedge i_reset_n)
        if (!i_reset_n) begin
            pattern <= MAX_LEN'(4'b1010);
            len     <= LEN_W'(4);
            overlap <= 1'b1;
            hist    <= '0;
            fill    <= '0;
            count   <= '0;
            timer   <= '0;
            match_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (cfg_ok) begin
                pattern <= bus.i_cfg_pattern;
                len     <= bus.i_cfg_len;
                overlap <= bus.i_cfg_overlap;
            end
            hist    <= arm_go ? '0 : accept ? hist_n : hist;
            fill    <= arm_go ? '0 : !accept ? fill : (hit && !overlap) ? '0 : fill_inc;
            count   <= arm_go ? '0 : (hit && count != '1) ? count + 1'b1 : count;
            timer   <= hit ? TW'(HOLD_CYC) : (timer != '0) ? timer - 1'b1 : timer;
            match_q <= hit;
            err_q   <= bus.i_cfg_we && !cfg_ok;
        end

    assign bus.o_cfg_ready   = state == IDLE;
    assign bus.o_busy        = state == ARMED;
    assign bus.o_match       = match_q;
    assign bus.o_led         = timer != '0;
    assign bus.o_match_count = count;
    assign bus.o_cfg_err     = err_q;
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb_seq_detect_ctrl: directed vectors against hand-computed results; a CNT_W=2
// copy receives the same stimulus to exercise counter saturation.
`timescale 1ns/1ps
module tb_seq_detect_ctrl;
    logic i_clock = 1'b0;
    logic i_reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    seq_detect_ctrl_if #(.MAX_LEN(8), .CNT_W(8)) bus ();
    seq_detect_ctrl_if #(.MAX_LEN(8), .CNT_W(2)) bus2 ();

    seq_detect_ctrl #(.MAX_LEN(8), .CNT_W(8), .HOLD_CYC(4)) dut (
        .i_clock(i_clock), .i_reset_n(i_reset_n), .bus(bus.slave));
    seq_detect_ctrl #(.MAX_LEN(8), .CNT_W(2), .HOLD_CYC(4)) dut2 (
        .i_clock(i_clock), .i_reset_n(i_reset_n), .bus(bus2.slave));

    assign bus2.i_cfg_we      = bus.i_cfg_we;
    assign bus2.i_cfg_pattern = bus.i_cfg_pattern;
    assign bus2.i_cfg_len     = bus.i_cfg_len;
    assign bus2.i_cfg_overlap = bus.i_cfg_overlap;
    assign bus2.i_arm         = bus.i_arm;
    assign bus2.i_disarm      = bus.i_disarm;
    assign bus2.i_bit_valid   = bus.i_bit_valid;
    assign bus2.i_bit         = bus.i_bit;

    always #5 i_clock = ~i_clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    task automatic feed(input logic b, input logic exp_match);
        bus.i_bit_valid = 1'b1;
        bus.i_bit = b;
        step();
        bus.i_bit_valid = 1'b0;
        check("match", 32'(bus.o_match), 32'(exp_match));
    endtask

    task automatic cfg_write(input logic [7:0] pat, input logic [3:0] len, input logic ovl, input logic arm);
        bus.i_cfg_we = 1'b1;
        bus.i_cfg_pattern = pat;
        bus.i_cfg_len = len;
        bus.i_cfg_overlap = ovl;
        bus.i_arm = arm;
        step();
        bus.i_cfg_we = 1'b0;
        bus.i_arm = 1'b0;
    endtask

    task automatic ctl(input logic arm, input logic disarm);
        bus.i_arm = arm;
        bus.i_disarm = disarm;
        step();
        bus.i_arm = 1'b0;
        bus.i_disarm = 1'b0;
    endtask

    initial begin
        bus.i_cfg_we = 1'b0;
        bus.i_cfg_pattern = '0;
        bus.i_cfg_len = '0;
        bus.i_cfg_overlap = 1'b0;
        bus.i_arm = 1'b0;
        bus.i_disarm = 1'b0;
        bus.i_bit_valid = 1'b0;
        bus.i_bit = 1'b0;
        #1;
        check("rst_ready", 32'(bus.o_cfg_ready), 1);
        check("rst_busy", 32'(bus.o_busy), 0);
        check("rst_match", 32'(bus.o_match), 0);
        check("rst_led", 32'(bus.o_led), 0);
        check("rst_count", 32'(bus.o_match_count), 0);
        check("rst_err", 32'(bus.o_cfg_err), 0);
        #11 i_reset_n = 1'b1;
        step();

        // default 1010, overlapping
        ctl(1, 0);
        check("arm_busy", 32'(bus.o_busy), 1);
        check("arm_ready", 32'(bus.o_cfg_ready), 0);
        for (int i = 1; i <= 6; i++) feed(i % 2, i == 4 || i == 6);
        check("ovl_count", 32'(bus.o_match_count), 2);
        check("ovl_led0", 32'(bus.o_led), 1);
        for (int i = 1; i <= 4; i++) begin
            step();
            check("ovl_led", 32'(bus.o_led), 32'(i < 4));
        end

        // non-overlapping 1010
        ctl(0, 1);
        check("disarm_ready", 32'(bus.o_cfg_ready), 1);
        cfg_write(8'b1010, 4, 0, 0);
        check("cfg_ok_err", 32'(bus.o_cfg_err), 0);
        ctl(1, 0);
        for (int i = 1; i <= 6; i++) feed(i % 2, i == 4);
        check("novl_count", 32'(bus.o_match_count), 1);

        // 111 overlapping, written in the arming cycle
        ctl(0, 1);
        cfg_write(8'b111, 3, 1, 1);
        check("armcfg_busy", 32'(bus.o_busy), 1);
        check("armcfg_err", 32'(bus.o_cfg_err), 0);
        for (int i = 1; i <= 5; i++) begin
            feed(1, i >= 3);
            if (i >= 3) check("ones_led", 32'(bus.o_led), 1);
        end
        check("ones_count", 32'(bus.o_match_count), 3);
        for (int i = 1; i <= 4; i++) begin
            step();
            check("ones_led_tail", 32'(bus.o_led), 32'(i < 4));
        end

        // rejected writes keep the previous config
        ctl(0, 1);
        cfg_write(8'b1010, 4, 1, 0);
        ctl(1, 0);
        cfg_write(8'b111, 3, 1, 0);
        check("err_armed", 32'(bus.o_cfg_err), 1);
        step();
        check("err_pulse_end", 32'(bus.o_cfg_err), 0);
        ctl(0, 1);
        cfg_write(8'b111, 0, 1, 0);
        check("err_len0", 32'(bus.o_cfg_err), 1);
        cfg_write(8'b111, 9, 1, 0);
        check("err_len9", 32'(bus.o_cfg_err), 1);
        step();
        check("err_clear", 32'(bus.o_cfg_err), 0);
        ctl(1, 0);
        for (int i = 1; i <= 4; i++) feed(i % 2, i == 4);

        // saturation and re-arm clearing
        ctl(0, 1);
        ctl(1, 0);
        for (int i = 1; i <= 20; i++) feed(i % 2, i >= 4 && i % 2 == 0);
        check("sat_count8", 32'(bus.o_match_count), 9);
        check("sat_count2", 32'(bus2.o_match_count), 3);
        ctl(0, 1);
        ctl(1, 0);
        check("rearm_count8", 32'(bus.o_match_count), 0);
        check("rearm_count2", 32'(bus2.o_match_count), 0);
        ctl(1, 1);
        check("both_armed_busy", 32'(bus.o_busy), 0);
        check("both_armed_ready", 32'(bus.o_cfg_ready), 1);
        ctl(1, 1);
        check("both_idle_busy", 32'(bus.o_busy), 0);

        // async reset mid-stream restores the default pattern
        cfg_write(8'b0110, 4, 1, 0);
        ctl(1, 0);
        feed(0, 0);
        feed(1, 0);
        feed(1, 0);
        feed(0, 1);
        check("pre_rst_led", 32'(bus.o_led), 1);
        #2 i_reset_n = 1'b0;
        #1;
        check("async_ready", 32'(bus.o_cfg_ready), 1);
        check("async_busy", 32'(bus.o_busy), 0);
        check("async_match", 32'(bus.o_match), 0);
        check("async_led", 32'(bus.o_led), 0);
        check("async_count", 32'(bus.o_match_count), 0);
        #1 i_reset_n = 1'b1;
        step();
        ctl(1, 0);
        for (int i = 1; i <= 4; i++) feed(i % 2, i == 4);
        check("post_rst_count", 32'(bus.o_match_count), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Programmable controller for the button-driven sequence detector path. It holds the detector configuration: pattern, length and overlap mode. It arms and disarms detection, accepts a qualified bit stream, flags matches, keeps a saturating match count and pulse-stretches the LED indication. It sits between the debounced button/bit source and the board LED, replacing a hard-wired pattern FSM.

## Interface
- MAX_LEN, 8, maximum pattern length in bits (2..16)
- LEN_W, $clog2(MAX_LEN+1), width of length field
- CNT_W, 8, match counter width
- HOLD_CYC, 4, LED stretch length in cycles (>=1)

- i_clock  in  1  single clock, all state on rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_cfg_we  in  1  configuration write strobe
- i_cfg_pattern  in  MAX_LEN  pattern; bit len-1 = first bit expected, bit 0 = last
- i_cfg_len  in  LEN_W  pattern length
- i_cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
- i_arm  in  1  start detection (level sampled each cycle)
- i_disarm  in  1  stop detection
- i_bit_valid  in  1  i_bit qualifier
- i_bit  in  1  serial input bit
- o_cfg_ready  out  1  high in IDLE (config writes accepted)
- o_busy  out  1  high in ARMED
- o_match  out  1  one-cycle match pulse
- o_led  out  1  stretched match indication
- o_match_count  out  CNT_W  saturating match count since last arm
- o_cfg_err  out  1  one-cycle pulse on rejected config write

## Operation
- FSM states: IDLE, ARMED. IDLE -> ARMED on i_arm. ARMED -> IDLE on i_disarm. Both asserted in IDLE: stay IDLE. Both asserted in ARMED: go IDLE (disarm wins).
- Reset (async, i_reset_n low): state IDLE, history 0, fill 0, count 0, LED timer 0, pattern = 'b1010 (zero-extended), len 4, overlap 1. Outputs: o_cfg_ready 1, all other outputs 0.
- Config write: accepted only in IDLE with 1 <= i_cfg_len <= MAX_LEN. Pattern, len and overlap are captured together. A write in ARMED or with an illegal len leaves config unchanged and pulses o_cfg_err for one cycle. A write in the same cycle as i_arm in IDLE is accepted, and the new config applies to that arm.
- Arm transition: history, fill and o_match_count are cleared; the config is frozen until IDLE.
- Bit accept: i_bit_valid high in ARMED, and not in a disarming cycle. History shifts left with i_bit entering bit 0. Fill = min(fill+1, len).
- Match condition, evaluated on the updated history: fill reaches len and history[len-1:0] == pattern[len-1:0]. Bits above len are ignored.
- On match, overlap=1: fill stays at len, so the next bit can complete another match. Overlap=0: fill cleared to 0, and the following len bits must all be new.
- Count increments on each match and saturates at 2^CNT_W-1.
- LED timer reloads to HOLD_CYC on each match, including retrigger while running. Otherwise it decrements toward 0. o_led = (timer != 0). The timer keeps running after disarm.
- Bits with i_bit_valid low, or presented in IDLE, are ignored.

## Timing
- Bit accepted at edge k: o_match, the count increment and o_led rise are visible after edge k. This is one edge of latency, all registered.
- o_match is high for exactly one cycle per match. Back-to-back matches on consecutive valid bits give back-to-back pulses.
- o_led stays high HOLD_CYC cycles after the last match.
- o_cfg_err is asserted the cycle after the offending write edge.
- o_busy and o_cfg_ready change at the edge that samples i_arm / i_disarm.
- Reset assertion mid-stream clears everything immediately, with no clock edge needed. Release is sampled at the next rising edge.

## Test plan
- Reset config, arm, stream 1,0,1,0,1,0 (valid each cycle) -> o_match pulses after bits 4 and 6, count 2, o_led high 4 cycles after bit 6 edge.
- Write overlap=0 in IDLE, arm, same stream -> single pulse after bit 4, count 1.
- Write pattern 'b111, len 3, overlap 1. Arm and feed five 1s -> pulses after bits 3, 4, 5, count 3, o_led continuous until 4 cycles after bit 5.
- Config write while ARMED, and write with len 0 or len MAX_LEN+1 in IDLE -> o_cfg_err one cycle each, subsequent 1010 stream still matches the old config.
- CNT_W=2, stream 1010 repeated 5 times overlapping -> count sticks at 3. Disarm then re-arm -> count 0. Arm+disarm same cycle while ARMED -> IDLE.
- Drop i_reset_n between clock edges mid-stream -> all outputs 0 and o_cfg_ready 1 immediately. After release, the default pattern 1010 is active again.
